// File: rtl/button_pkg.sv
// Shared types and default sizing for the push-button conditioner.
// Imported by the per-channel block and the top wrapper.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned DEF_NUM_BUTTONS       = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 250000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 25000000;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce FSM, hold timer.
// All outputs are registered.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam bit BYPASS = (DEBOUNCE_CYCLES == 1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          was_down, is_down;
  logic          press_d, release_d, long_d;
  logic          level_q, press_q, release_q, long_q;

  // Flops idle high so reset looks like a released pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pin_n_i};
    end
  end

  assign s = ~sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (s) begin
          if (BYPASS) begin
            state_d = PRESSED;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = DW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          if (BYPASS) begin
            state_d = RELEASED;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = DW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign was_down = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign is_down  = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

  assign press_d   = !was_down && is_down;
  assign release_d = was_down && !is_down;

  // Hold time freezes in RELEASE_WAIT so a bounce does not lose it.
  always_comb begin
    hold_d = hold_q;
    if (press_d || !is_down) begin
      hold_d = '0;
    end else if ((state_q == PRESSED) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end
  end

  assign long_d = (hold_q != HOLD_MAX) && (hold_d == HOLD_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      level_q   <= is_down;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Array of independent debounced push-button channels.
// Raw pins are active-low; all outputs are active-high.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS       = DEF_NUM_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] push_button_n,
  output logic [NUM_BUTTONS-1:0] push_button,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .pin_n_i  (push_button_n[i]),
      .level_o  (push_button[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i]),
      .long_o   (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: driver queues expected output events by cycle,
// a negedge monitor pops and compares each event the DUT produces.
module tb_button_conditioner;
  import button_pkg::*;

  typedef struct {
    int         cyc;
    logic [1:0] pb;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lp;
  } ev_t;

  logic       clock;
  logic       reset_n;
  logic [1:0] pins;
  logic [1:0] pb, pr, rl, lp;
  logic [1:0] pb_prev;
  int         cyc;
  int         n_chk;
  int         n_pass;
  ev_t        sbq[$];

  button_conditioner #(
    .NUM_BUTTONS      (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10)
  ) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .push_button_n(pins),
    .push_button  (pb),
    .press_pulse  (pr),
    .release_pulse(rl),
    .long_press   (lp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    pb_prev = 2'b00;
    forever begin
      @(negedge clock);
      if (pb != pb_prev || pr != 2'b00 || rl != 2'b00 || lp != 2'b00) begin
        n_chk++;
        if (sbq.size() == 0) begin
          $display("FAIL event: unexpected at cyc %0d pb=%b pr=%b rl=%b lp=%b, want none",
                   cyc, pb, pr, rl, lp);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          if (e.cyc == cyc && e.pb == pb && e.pr == pr && e.rl == rl && e.lp == lp) begin
            n_pass++;
          end else begin
            $display("FAIL event: got cyc %0d pb=%b pr=%b rl=%b lp=%b, want cyc %0d pb=%b pr=%b rl=%b lp=%b",
                     cyc, pb, pr, rl, lp, e.cyc, e.pb, e.pr, e.rl, e.lp);
          end
        end
      end
      pb_prev = pb;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [1:0] b, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] l);
    ev_t e;
    e.cyc = c;
    e.pb  = b;
    e.pr  = p;
    e.rl  = r;
    e.lp  = l;
    sbq.push_back(e);
  endtask

  task automatic check_empty(input string nm);
    n_chk++;
    if (sbq.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL %s: %0d events still pending, want 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_quiet(input string nm);
    n_chk++;
    if ({pb, pr, rl, lp} == 8'h00) begin
      n_pass++;
    end else begin
      $display("FAIL %s: outputs pb=%b pr=%b rl=%b lp=%b, want all 0", nm, pb, pr, rl, lp);
    end
  endtask

  task automatic check_released(input string nm);
    n_chk++;
    if (u_dut.g_ch[0].u_ch.state_q == RELEASED) begin
      n_pass++;
    end else begin
      $display("FAIL %s: ch0 state %0d, want RELEASED", nm, u_dut.g_ch[0].u_ch.state_q);
    end
  endtask

  initial begin
    int t;
    int u;
    int r;
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    pins    = 2'b11;
    step(3);
    check_quiet("reset_outputs");
    check_released("reset_state");
    reset_n = 1'b1;
    step(3);

    // single press, long press, saturate, release
    t = cyc;
    pins[0] = 1'b0;
    expect_ev(t + 7, 2'b01, 2'b01, 2'b00, 2'b00);
    expect_ev(t + 17, 2'b01, 2'b00, 2'b00, 2'b01);
    step(27);
    r = cyc;
    pins[0] = 1'b1;
    expect_ev(r + 7, 2'b00, 2'b00, 2'b01, 2'b00);
    step(10);
    check_empty("press_long_release");

    // short glitch
    pins[0] = 1'b0;
    step(3);
    pins[0] = 1'b1;
    step(7);
    check_released("glitch_state");
    check_empty("glitch_quiet");

    // simultaneous press on both channels
    t = cyc;
    pins = 2'b00;
    expect_ev(t + 7, 2'b11, 2'b11, 2'b00, 2'b00);
    step(10);
    pins = 2'b11;
    expect_ev(t + 17, 2'b00, 2'b00, 2'b11, 2'b00);
    step(10);
    check_empty("both_channels");

    // reset while pressed
    t = cyc;
    pins[0] = 1'b0;
    expect_ev(t + 7, 2'b01, 2'b01, 2'b00, 2'b00);
    step(9);
    reset_n = 1'b0;
    expect_ev(cyc, 2'b00, 2'b00, 2'b00, 2'b00);
    #1;
    check_quiet("reset_mid_press");
    step(3);
    u = cyc;
    reset_n = 1'b1;
    expect_ev(u + 7, 2'b01, 2'b01, 2'b00, 2'b00);
    step(10);
    r = cyc;
    pins[0] = 1'b1;
    expect_ev(r + 7, 2'b00, 2'b00, 2'b01, 2'b00);
    step(10);
    check_empty("reset_repress");

    // release bounce pauses the hold timer by six cycles
    t = cyc;
    pins[0] = 1'b0;
    expect_ev(t + 7, 2'b01, 2'b01, 2'b00, 2'b00);
    expect_ev(t + 23, 2'b01, 2'b00, 2'b00, 2'b01);
    step(8);
    for (int i = 0; i < 5; i++) begin
      pins[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(2);
    end
    pins[0] = 1'b0;
    step(12);
    r = cyc;
    pins[0] = 1'b1;
    expect_ev(r + 7, 2'b00, 2'b00, 2'b01, 2'b00);
    step(10);
    check_empty("bounce_resume");
    check_released("final_state");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter NUM_BUTTONS, default 2, the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, the consecutive stable synchronized samples required to accept a level change (legal range 1 to 2^20).
REQ-003 The block SHALL have parameter LONG_PRESS_CYCLES, default 25000000, the cycles spent in PRESSED before long_press fires (legal range 1 to 2^28).
REQ-004 The block SHALL have port clock, input, 1 bit, the sole clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-006 The block SHALL have port push_button_n, input, NUM_BUTTONS bits, raw active-low asynchronous pin levels.
REQ-007 The block SHALL have port push_button, output, NUM_BUTTONS bits, the debounced active-high level.
REQ-008 The block SHALL have port press_pulse, output, NUM_BUTTONS bits, a one-cycle pulse on each accepted press.
REQ-009 The block SHALL have port release_pulse, output, NUM_BUTTONS bits, a one-cycle pulse on each accepted release.
REQ-010 The block SHALL have port long_press, output, NUM_BUTTONS bits, a one-cycle pulse after a press is held for LONG_PRESS_CYCLES.

Function
REQ-011 Each channel SHALL pass its pin through a two-flop synchronizer, then invert the result to the active-high sample s.
REQ-012 Each channel SHALL run an FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In RELEASED, the FSM SHALL move to PRESS_WAIT with count=1 when s=1, and SHALL stay otherwise.
REQ-014 In PRESS_WAIT, the FSM SHALL return to RELEASED with count cleared when s=0.
REQ-015 In PRESS_WAIT, when s=1 and count=DEBOUNCE_CYCLES, the FSM SHALL go to PRESSED; otherwise it SHALL increment count.
REQ-016 For DEBOUNCE_CYCLES=1, PRESS_WAIT SHALL be bypassed: RELEASED goes directly to PRESSED on s=1.
REQ-017 RELEASE_WAIT SHALL behave as PRESS_WAIT with the polarity of s inverted, returning to PRESSED on s=1.
REQ-018 On entry to PRESSED, the block SHALL set push_button=1 and pulse press_pulse=1 for exactly one cycle, both registered.
REQ-019 On entry to RELEASED from RELEASE_WAIT, the block SHALL set push_button=0 and pulse release_pulse=1 for exactly one cycle.
REQ-020 push_button SHALL rise DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the pin low, given a stable pin.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change and SHALL restart the count.
REQ-022 The hold counter SHALL clear on entry to PRESSED, increment while in PRESSED, and pulse long_press once when it reaches LONG_PRESS_CYCLES.
REQ-023 The hold counter SHALL then saturate (no repeat) and SHALL clear on release.
REQ-024 The hold counter SHALL pause, not clear, during RELEASE_WAIT, and SHALL resume if the FSM returns to PRESSED.
REQ-025 Channels SHALL be fully independent; simultaneous events SHALL produce pulses on the same cycle.
REQ-026 press_pulse and release_pulse of one channel SHALL never be asserted together.
REQ-027 Counters SHALL be sized $clog2(parameter+1) bits and SHALL never wrap.

Reset
REQ-028 While reset_n=0, all outputs SHALL be 0, all FSMs SHALL be in RELEASED, counters SHALL be 0, and synchronizer flops SHALL be 1 (idle pin level).
REQ-029 Reset asserted mid-press SHALL produce no release_pulse; after deassertion, a held button SHALL be re-debounced and SHALL yield a fresh press_pulse.

Structure
REQ-030 Shared package button_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 The block SHALL use one sub-module, button_channel (synchronizer, FSM, both counters), instantiated NUM_BUTTONS times in a generate loop.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-032 Bench SHALL check: pin0 low, held -> push_button[0]=1 and one press_pulse[0] at edge 7 after the first low sample; bit 1 stays 0.
REQ-033 Bench SHALL check: pin0 low for 3 cycles then high -> no output activity; FSM back in RELEASED.
REQ-034 Bench SHALL check: press held 20 cycles, then released -> exactly one long_press[0] 10 cycles after press_pulse, then one release_pulse[0] 7 edges after the pin rises.
REQ-035 Bench SHALL check: both pins low on the same edge -> press_pulse=2'b11 on a single cycle.
REQ-036 Bench SHALL check: reset_n pulsed low while PRESSED -> outputs 0 immediately, no release_pulse; pin still low -> new press_pulse 7 edges after reset_n rises.
REQ-037 Bench SHALL check: during release, pin bounces high/low every 2 cycles for 10 cycles -> push_button stays 1 with no pulses, and long_press timing resumes from its paused count.
